// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop,
// WIDTH-bit operands processed LSB-first under a start/busy/done handshake.
// Subtraction is a + ~b + 1: B is inverted at capture and the carry is
// preloaded with 1.
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_s;
    logic             r_co;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic             w_sum;
    logic             w_carry;
    logic             w_last;
    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] w_res_next;

    // Full-adder cell on the current LSBs, and the operand B as it is captured.
    always_comb begin
        w_sum      = r_a[0] ^ r_b[0] ^ r_carry;
        w_carry    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
        w_last     = (r_cnt == CW'(WIDTH - 1));
        w_b_in     = sub ? ~b : b;
        w_res_next = {w_sum, r_res[WIDTH-1:1]};
    end

    // Control FSM with the serial datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Operand MSBs are kept aside: the shift registers
                        // lose them before the overflow decision is made.
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= w_b_in[WIDTH-1];
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_res_next;
                    r_carry <= w_carry;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_s     <= w_res_next;
                        r_co    <= w_carry;
                        r_ovf   <= (r_a_msb == r_b_msb) && (w_sum != r_a_msb);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s    = r_s;
    assign co   = r_co;
    assign ovf  = r_ovf;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub (WIDTH = 4): directed cases plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_serial_addsub;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       co;
    logic       ovf;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    serial_addsub #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .s     (s),
        .co    (co),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, co, s} from unsigned/signed integer arithmetic.
    function automatic logic [5:0] model(input int ua, input int ub, input bit is_sub);
        int  r;
        int  sa;
        int  sb;
        int  sr;
        bit  mco;
        bit  movf;
        r    = is_sub ? ua - ub : ua + ub;
        mco  = is_sub ? (ua >= ub) : (r >= 16);
        sa   = (ua >= 8) ? ua - 16 : ua;
        sb   = (ub >= 8) ? ub - 16 : ub;
        sr   = is_sub ? sa - sb : sa + sb;
        movf = (sr > 7) || (sr < -8);
        return {movf, mco, 4'(r & 15)};
    endfunction

    // Issue one operation, watch it run, and check latency, hold and result.
    // Returns in the cycle where done is high.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb,
                          input bit tsub, input bit junk);
        logic [5:0] e;
        logic [3:0] ps;
        logic       pco;
        logic       povf;
        int         n;
        int         nb;
        e    = model(int'(ta), int'(tb), tsub);
        ps   = s;
        pco  = co;
        povf = ovf;
        a     = ta;
        b     = tb;
        sub   = tsub;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a     = 4'($urandom);
        b     = 4'($urandom);
        sub   = 1'($urandom);
        n  = 0;
        nb = 0;
        while (done !== 1'b1 && n < 12) begin
            if (busy === 1'b1) nb++;
            chk("hold_s", 32'(s), 32'(ps));
            chk("hold_co", 32'(co), 32'(pco));
            chk("hold_ovf", 32'(ovf), 32'(povf));
            if (junk && (n == 1 || n == 2)) begin
                start = 1'b1;
                a     = 4'd9;
                b     = 4'd9;
                sub   = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("latency", 32'(n), 32'd4);
        chk("busy_cycles", 32'(nb), 32'd4);
        chk("done", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("s", 32'(s), 32'(e[3:0]));
        chk("co", 32'(co), 32'(e[4]));
        chk("ovf", 32'(ovf), 32'(e[5]));
    endtask

    task automatic idle_chk();
        @(posedge clk); #1;
        chk("done_single", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(4'd5, 4'd3, 1'b0, 1'b0);
        idle_chk();
        run_op(4'd15, 4'd1, 1'b0, 1'b0);
        idle_chk();
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_hold_s", 32'(s), 32'd0);
        end
        run_op(4'd7, 4'd2, 1'b1, 1'b0);
        idle_chk();
        run_op(4'd2, 4'd7, 1'b1, 1'b0);
        idle_chk();

        // Back-to-back: second start is presented in the done cycle.
        run_op(4'd8, 4'd1, 1'b1, 1'b0);
        run_op(4'd1, 4'd1, 1'b0, 1'b0);
        idle_chk();

        // Extra starts during RUN are ignored.
        run_op(4'd3, 4'd4, 1'b0, 1'b1);
        idle_chk();
        idle_chk();

        // Asynchronous reset in the middle of an operation.
        a     = 4'd6;
        b     = 4'd6;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_s", 32'(s), 32'd0);
        chk("abort_co", 32'(co), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_abort_idle", 32'(busy), 32'd0);
        run_op(4'd1, 4'd2, 1'b0, 1'b0);
        idle_chk();

        // Randomized operations, some issued back-to-back.
        for (int i = 0; i < 60; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            bit         rs;
            bit         b2b;
            ra  = 4'($urandom);
            rb  = 4'($urandom);
            rs  = 1'($urandom);
            b2b = 1'($urandom);
            run_op(ra, rb, rs, 1'b0);
            if (!b2b) idle_chk();
        end
        idle_chk();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial adder/subtractor built around one full-adder cell and a carry flip-flop.
- Processes WIDTH-bit operands LSB-first, one bit per clock, under a start/busy/done handshake.
- It is the sequential, subtract-capable counterpart to the team's parallel full-adder blocks, and is the arithmetic unit used where area matters more than latency.

Parameters:
- WIDTH, 4, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request an operation; sampled on rising clk edges.
- sub  input  1  0 = a+b, 1 = a-b; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- s  output  WIDTH  result, registered.
- co  output  1  carry out; for subtract, 1 = no borrow (a >= b unsigned).
- ovf  output  1  two's-complement signed overflow flag.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse when s/co/ovf are updated.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - State = IDLE.
  - s = 0, co = 0, ovf = 0, busy = 0, done = 0.
  - Internal shift registers, carry and bit counter = 0.
- Reset mid-operation aborts immediately. No done pulse is produced and outputs return to their reset values.
- States: IDLE, RUN, DONE.
- IDLE, start = 1 at edge k:
  - Capture A = a and B' = sub ? ~b : b.
  - Set carry = sub and count = 0.
  - Go to RUN. busy = 1 from edge k.
- RUN, each edge:
  - sum = A[0] ^ B'[0] ^ carry; carry <= majority(A[0], B'[0], carry).
  - Shift A and B' right by one.
  - Shift sum into the MSB of an internal result register.
  - count <= count + 1.
- RUN, edge processing bit WIDTH-1 (edge k+WIDTH):
  - s <= completed result register.
  - co <= final carry.
  - ovf <= (A_msb == B'_msb) && (sum_msb != A_msb), using the operand MSBs as captured.
  - busy <= 0, done <= 1, go to DONE.
- DONE: done is high for exactly one cycle (the cycle after edge k+WIDTH).
  - Next edge: start = 1 accepts a new operation (DONE -> RUN, same capture as from IDLE). Otherwise go to IDLE.
  - done deasserts on that edge in either case.
- Latency: done high in the cycle after edge k+WIDTH. Back-to-back throughput is one result per WIDTH+1 cycles.
- start while in RUN (busy = 1) is ignored. Operands and sub are not re-sampled and the operation continues undisturbed.
- s, co and ovf hold their last values until the next completion. They do not change during RUN.
- Arithmetic is modulo 2^WIDTH and the result wraps. Subtract is computed as a + ~b + 1.
- Counter width: clog2(WIDTH) + 1 bits. Wrap of the counter is never relied upon.
- a, b and sub may change freely after the capture edge without affecting the result.

Test Plan (WIDTH = 4):
- Reset, then add 5 + 3 (start one cycle) -> busy high for 4 cycles; done pulses once in the 5th cycle; s = 8, co = 0, ovf = 1.
- Add 15 + 1 -> s = 0, co = 1, ovf = 0. Check that s holds 0 until the next done.
- Subtract 7 - 2 -> s = 5, co = 1, ovf = 0. Then subtract 2 - 7 -> s = 11 (4'hB), co = 0, ovf = 0.
- Subtract 8 - 1 (i.e. -8 - 1 signed) -> s = 7, co = 1, ovf = 1. Then start again in the DONE cycle with 1 + 1 -> accepted without passing through IDLE; s = 2 after 4 further cycles.
- Start 3 + 4, then pulse start with a = 9, b = 9, sub = 1 at cycles 2 and 3 of RUN -> the extra starts are ignored; s = 7, co = 0, ovf = 0; exactly one done pulse.
- Start 6 + 6, then assert rst_n = 0 asynchronously (between edges) at cycle 2 of RUN -> all outputs are 0 immediately; no done pulse. After release, 1 + 2 -> s = 3.
